instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/package_project_typedefs.sv | 24 ++
 rtl/fetch_buffer.sv | 82 ++++++++
 rtl/instruction_fetch.sv | 128 ++++++++++++
 tb/tb_instruction_fetch.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/package_project_typedefs.sv
//------------------------------------------------------------------------------
// Module  : package_project_typedefs
// Brief   : Shared types and constants for the instruction fetch slice.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package package_project_typedefs;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } FetchState;

    localparam logic [31:0] INST_BYTES = 32'd4;

    localparam int unsigned FETCH_BUF_DEPTH = 2;
    localparam int unsigned FETCH_BUF_WIDTH = 64;

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
//------------------------------------------------------------------------------
// Module  : fetch_buffer
// Brief   : Small circular FIFO with flush; head entry is presented directly.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fetch_buffer #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign do_pop      = pop_i && !empty_o;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_push     = push_i && (!full_o || do_pop);
    assign head_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
//------------------------------------------------------------------------------
// Module  : instruction_fetch
// Brief   : Single-outstanding instruction fetch unit with redirect handling.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module instruction_fetch
    import package_project_typedefs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam logic [31:0] ALIGN_MASK = ~32'h3;

    FetchState   state_q;
    FetchState   state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;

    logic        req_fire;
    logic        rsp_push;
    logic        inst_pop;
    logic        buf_full;
    logic        buf_empty;
    logic [31:0] redirect_target;
    logic [31:0] rsp_pc;
    logic [63:0] buf_head;

    assign redirect_target = redirect_pc & ALIGN_MASK;

    // With nothing outstanding the FIFO occupancy alone bounds issue.
    assign imem_req_valid  = rst_n && (state_q == FETCH) && !buf_full;
    assign imem_addr       = pc_q;
    assign req_fire        = imem_req_valid && imem_req_ready;

    // pc_q has already stepped past the outstanding request.
    assign rsp_pc          = pc_q - INST_BYTES;

    assign inst_pop        = inst_valid && inst_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rsp_push = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (req_fire) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_d  = FETCH;
                    rsp_push = !redirect_valid;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (req_fire) begin
            pc_d = pc_q + INST_BYTES;
        end

        // A request still in flight after a redirect belongs to the old path.
        if (redirect_valid) begin
            pc_d = redirect_target;
            if (state_d == WAIT) begin
                state_d = DRAIN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC & ALIGN_MASK;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_buffer #(
        .DEPTH (FETCH_BUF_DEPTH),
        .WIDTH (FETCH_BUF_WIDTH)
    ) u_fetch_buffer (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (rsp_push),
        .push_data_i ({rsp_pc, imem_rsp_data}),
        .pop_i       (inst_pop),
        .flush_i     (redirect_valid),
        .head_data_o (buf_head),
        .full_o      (buf_full),
        .empty_o     (buf_empty)
    );

    assign inst_valid = !buf_empty;
    assign inst_pc    = buf_head[63:32];
    assign inst       = buf_head[31:0];

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
//------------------------------------------------------------------------------
// Module  : tb_instruction_fetch
// Brief   : Self-checking bench for instruction_fetch against a queue model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    logic        w_rst_n;
    logic        w_req_valid;
    logic        w_req_ready;
    logic [31:0] w_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_redir;
    logic [31:0] w_rpc;
    logic        w_inst_valid;
    logic        w_inst_ready;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;
    logic        w_done = 1'b0;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(w_rst_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_addr(w_addr), .imem_rsp_valid(w_rsp_valid),
        .imem_rsp_data(w_rsp_data), .redirect_valid(w_redir),
        .redirect_pc(w_rpc), .inst_valid(w_inst_valid),
        .inst_ready(w_inst_ready), .inst(w_inst), .inst_pc(w_inst_pc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Behavioural model: queue of delivered words plus one outstanding slot.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    entry_t      m_fifo[$];
    bit          m_out;
    bit          m_stale;
    logic [31:0] m_pc;
    logic [31:0] m_out_pc;

    function automatic logic m_req_valid();
        return rst_n && !m_out && (m_fifo.size() < 2);
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_out   = 1'b0;
        m_stale = 1'b0;
        m_pc    = 32'h0000_0000;
    endtask

    task automatic model_update();
        bit fire;
        entry_t e;
        if (!rst_n) return;
        fire = m_req_valid() && imem_req_ready;
        if (m_fifo.size() > 0 && inst_ready) void'(m_fifo.pop_front());
        if (m_out && imem_rsp_valid) begin
            if (!m_stale && !redirect_valid) begin
                e.pc   = m_out_pc;
                e.word = imem_rsp_data;
                m_fifo.push_back(e);
            end
            m_out = 1'b0;
        end
        if (fire) begin
            m_out    = 1'b1;
            m_stale  = 1'b0;
            m_out_pc = m_pc;
            m_pc     = m_pc + 32'd4;
        end
        if (redirect_valid) begin
            m_fifo.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
            if (m_out) m_stale = 1'b1;
        end
    endtask

    task automatic compare_outputs();
        chk1("req_valid", imem_req_valid, m_req_valid());
        chk("imem_addr", imem_addr, m_pc);
        chk1("inst_valid", inst_valid, m_fifo.size() > 0);
        if (m_fifo.size() > 0) begin
            chk("inst", inst, m_fifo[0].word);
            chk("inst_pc", inst_pc, m_fifo[0].pc);
        end
    endtask

    // Instruction-memory environment and stimulus knobs.
    bit          pend;
    int          pend_delay;
    logic [31:0] pend_addr;
    logic [31:0] last_fire_addr;
    int unsigned cfg_ready_pct  = 100;
    int unsigned cfg_iready_pct = 100;
    int unsigned cfg_redir_pct  = 0;
    int unsigned cfg_lat_min    = 1;
    int unsigned cfg_lat_max    = 1;

    task automatic step(input bit do_redir = 1'b0, input logic [31:0] rpc = 32'h0);
        if (pend && pend_delay == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(pend_addr);
            pend           = 1'b0;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom();
            if (pend) pend_delay--;
        end
        imem_req_ready = ($urandom_range(99) < cfg_ready_pct);
        inst_ready     = ($urandom_range(99) < cfg_iready_pct);
        redirect_valid = do_redir || ($urandom_range(99) < cfg_redir_pct);
        redirect_pc    = do_redir ? rpc : $urandom();
        @(negedge clk);
        compare_outputs();
        if (imem_req_valid && imem_req_ready) begin
            pend           = 1'b1;
            pend_delay     = int'($urandom_range(cfg_lat_max, cfg_lat_min)) - 1;
            pend_addr      = imem_addr;
            last_fire_addr = imem_addr;
        end
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        pend           = 1'b0;
        model_reset();
        @(negedge clk);
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_addr", imem_addr, 32'h0000_0000);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk1("req_after_rst", imem_req_valid, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Second instance only demonstrates the wrap from the top of the space.
    initial begin
        logic [31:0] wexp [3];
        int n;
        bit fired;
        wexp[0] = 32'hFFFF_FFF8;
        wexp[1] = 32'hFFFF_FFFC;
        wexp[2] = 32'h0000_0000;
        n = 0;
        w_rst_n = 1'b0; w_req_ready = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = 32'h0;
        w_inst_ready = 1'b1; w_redir = 1'b0; w_rpc = 32'h0;
        @(negedge clk);
        chk("wrap_rst_addr", w_addr, 32'hFFFF_FFF8);
        @(posedge clk); #1;
        w_rst_n = 1'b1;
        for (int k = 0; k < 20 && n < 3; k++) begin
            @(negedge clk);
            fired = w_req_valid && w_req_ready;
            if (fired) begin
                chk("wrap_addr", w_addr, wexp[n]);
                n++;
            end
            @(posedge clk); #1;
            w_rsp_valid = fired;
            w_rsp_data  = word_of(w_addr);
        end
        chk("wrap_count", n, 3);
        w_done = 1'b1;
    end

    initial begin
        do_reset();

        // In-order stream: first inst two cycles after first transfer.
        step();
        chk("first_fire_addr", last_fire_addr, 32'h0);
        step();
        chk1("s30_valid0", inst_valid, 1'b1);
        chk("s30_pc0", inst_pc, 32'h0);
        chk("s30_inst0", inst, word_of(32'h0));
        step(); step();
        chk("s30_pc1", inst_pc, 32'h4);
        step(); step();
        chk("s30_pc2", inst_pc, 32'h8);

        // Back-pressure fills the buffer and stops requests.
        do_reset();
        cfg_iready_pct = 0;
        repeat (10) step();
        chk1("s31_req_stop", imem_req_valid, 1'b0);
        chk1("s31_valid", inst_valid, 1'b1);
        chk("s31_pc_hold", inst_pc, 32'h0);
        chk("s31_inst_hold", inst, word_of(32'h0));
        cfg_iready_pct = 100;
        step();
        chk("s31_next_pc", inst_pc, 32'h4);

        // Redirect while waiting on a slow response.
        do_reset();
        cfg_lat_min = 3; cfg_lat_max = 3;
        step(); step();
        step(1'b1, 32'h0000_0103);
        chk1("s32_drain_noreq", imem_req_valid, 1'b0);
        step();
        chk("s32_addr", imem_addr, 32'h0000_0100);
        chk1("s32_req", imem_req_valid, 1'b1);
        repeat (4) step();
        chk1("s32_valid", inst_valid, 1'b1);
        chk("s32_pc", inst_pc, 32'h0000_0100);

        // Redirect coinciding with the response.
        do_reset();
        cfg_lat_min = 1; cfg_lat_max = 1;
        step();
        step(1'b1, 32'h0000_0200);
        chk1("s33a_req", imem_req_valid, 1'b1);
        chk("s33a_addr", imem_addr, 32'h0000_0200);
        chk1("s33a_novalid", inst_valid, 1'b0);
        step();
        chk1("s33a_nostale", inst_valid, 1'b0);

        // Redirect coinciding with a transfer.
        do_reset();
        step(1'b1, 32'h0000_0300);
        chk1("s33b_drain", imem_req_valid, 1'b0);
        step();
        chk("s33b_addr", imem_addr, 32'h0000_0300);
        chk1("s33b_nostale", inst_valid, 1'b0);
        step(); step();
        chk("s33b_pc", inst_pc, 32'h0000_0300);

        // Reset pulse while a request is outstanding.
        do_reset();
        cfg_lat_min = 3; cfg_lat_max = 3;
        step(); step();
        rst_n = 1'b0;
        #1;
        chk1("s35_req", imem_req_valid, 1'b0);
        chk1("s35_valid", inst_valid, 1'b0);
        chk("s35_addr", imem_addr, 32'h0);
        chk("s35_inst", inst, 32'h0);
        chk("s35_pc", inst_pc, 32'h0);
        model_reset();
        cfg_ready_pct = 0;
        step();
        rst_n = 1'b1;
        step(); step();
        chk1("s35_ignored_rsp", inst_valid, 1'b0);
        cfg_ready_pct = 100;
        last_fire_addr = 32'hDEAD_BEEF;
        step();
        chk("s35_restart", last_fire_addr, 32'h0);

        // Randomised traffic with occasional resets.
        for (int seg = 0; seg < 5; seg++) begin
            do_reset();
            cfg_ready_pct  = $urandom_range(100, 40);
            cfg_iready_pct = $urandom_range(100, 30);
            cfg_redir_pct  = $urandom_range(10, 2);
            cfg_lat_min    = 1;
            cfg_lat_max    = $urandom_range(4, 1);
            repeat (600) step();
        end

        chk1("wrap_done", w_done, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
